// File: rtl/ecc_op_sequencer_if.sv
// Register-bank / datapath side bundle for the ECC operation sequencer.
// master drives requests and decoder status, slave is the sequencer.
interface ecc_op_sequencer_if;
    logic       start;
    logic [1:0] ctrl;
    logic [1:0] codeword_width;
    logic [1:0] dec_num_of_errors;
    logic       busy;
    logic       enc_en;
    logic       dec_en;
    logic       dec_sel_noised;
    logic       out_sel_dec;
    logic [1:0] width_lat;
    logic       operation_done;
    logic       op_error;
    logic [1:0] num_of_errors;

    modport master (
        output start, ctrl, codeword_width, dec_num_of_errors,
        input  busy, enc_en, dec_en, dec_sel_noised, out_sel_dec,
        input  width_lat, operation_done, op_error, num_of_errors
    );

    modport slave (
        input  start, ctrl, codeword_width, dec_num_of_errors,
        output busy, enc_en, dec_en, dec_sel_noised, out_sel_dec,
        output width_lat, operation_done, op_error, num_of_errors
    );
endinterface

// File: rtl/ecc_op_sequencer.sv
// ECC channel operation controller: sequences encoder/decoder enables
// for their fixed latencies and reports completion with the error count.
module ecc_op_sequencer #(
    parameter int ENC_LATENCY = 1,
    parameter int DEC_LATENCY = 2,
    parameter int CNT_WIDTH   = 4
) (
    input logic               clk,
    input logic               rst,
    ecc_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENC, DEC, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] ENC_LAST = CNT_WIDTH'(ENC_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] DEC_LAST = CNT_WIDTH'(DEC_LATENCY - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           op_lat;
    logic                 legal;

    assign legal = (bus.ctrl != 2'b11) && (bus.codeword_width != 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            op_lat             <= 2'b00;
            bus.busy           <= 1'b0;
            bus.enc_en         <= 1'b0;
            bus.dec_en         <= 1'b0;
            bus.dec_sel_noised <= 1'b0;
            bus.out_sel_dec    <= 1'b0;
            bus.width_lat      <= 2'b00;
            bus.operation_done <= 1'b0;
            bus.op_error       <= 1'b0;
            bus.num_of_errors  <= 2'b00;
        end else begin
            bus.operation_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && legal) begin
                        op_lat             <= bus.ctrl;
                        bus.width_lat      <= bus.codeword_width;
                        bus.num_of_errors  <= 2'b00;
                        bus.op_error       <= 1'b0;
                        cnt                <= '0;
                        bus.busy           <= 1'b1;
                        bus.out_sel_dec    <= (bus.ctrl != 2'b00);
                        bus.dec_sel_noised <= (bus.ctrl == 2'b10);
                        if (bus.ctrl == 2'b01) begin
                            state      <= DEC;
                            bus.dec_en <= 1'b1;
                        end else begin
                            state      <= ENC;
                            bus.enc_en <= 1'b1;
                        end
                    end else if (bus.start) begin
                        // illegal request: report it without touching latches
                        state              <= DONE;
                        bus.busy           <= 1'b1;
                        bus.op_error       <= 1'b1;
                        bus.operation_done <= 1'b1;
                    end
                end
                ENC: begin
                    if (cnt == ENC_LAST) begin
                        cnt        <= '0;
                        bus.enc_en <= 1'b0;
                        if (op_lat == 2'b10) begin
                            state      <= DEC;
                            bus.dec_en <= 1'b1;
                        end else begin
                            state              <= DONE;
                            bus.operation_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEC: begin
                    if (cnt == DEC_LAST) begin
                        cnt                <= '0;
                        bus.dec_en         <= 1'b0;
                        bus.num_of_errors  <= bus.dec_num_of_errors;
                        state              <= DONE;
                        bus.operation_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state              <= IDLE;
                    bus.busy           <= 1'b0;
                    bus.dec_sel_noised <= 1'b0;
                end
            endcase
        end
    end
endmodule
